// File: rtl/hold_detect_multi.sv
// hold_detect_multi: per-channel synchronized press/hold detector with short-press and hold pulses
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   btn_in       raw asynchronous per-channel requests, active-high
//   held         level, high while the channel is in HELD
//   hold_pulse   one-cycle pulse on HELD entry (plus repeat pulses with HOLD_AUTOREPEAT_EN)
//   short_press  one-cycle pulse on release of a press of MIN_PRESS_CYCLES..HOLD_CYCLES-1 samples
//   busy         high while any channel is not IDLE
// Define HOLD_AUTOREPEAT_EN to re-pulse hold_pulse every REPEAT_CYCLES edges while held.
module hold_detect_multi #(
    parameter int CHANNELS         = 4,
    parameter int HOLD_CYCLES      = 2000,
    parameter int MIN_PRESS_CYCLES = 20,
    parameter int REPEAT_CYCLES    = 500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic [CHANNELS-1:0] short_press,
    output logic                busy
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MINP = CW'(MIN_PRESS_CYCLES);
    typedef enum logic [1:0] {IDLE, PRESSING, HELD} state_t;
    logic [CHANNELS-1:0] s1, s2, hp_n, sp_n;
    state_t st [CHANNELS];
    state_t st_n [CHANNELS];
    logic [CW-1:0] cnt [CHANNELS];
    logic [CW-1:0] cnt_n [CHANNELS];
`ifdef HOLD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rc [CHANNELS];
    logic [RW-1:0] rc_n [CHANNELS];
`endif
    if (CHANNELS < 1 || CHANNELS > 16 || HOLD_CYCLES < 2 || MIN_PRESS_CYCLES < 1 ||
        MIN_PRESS_CYCLES >= HOLD_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("hold_detect_multi: parameter out of range");
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= '0;
            s2          <= '0;
            hold_pulse  <= '0;
            short_press <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
`ifdef HOLD_AUTOREPEAT_EN
                rc[i]  <= '0;
`endif
            end
        end else begin
            s1          <= btn_in;
            s2          <= s1;
            hold_pulse  <= hp_n;
            short_press <= sp_n;
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= st_n[i];
                cnt[i] <= cnt_n[i];
`ifdef HOLD_AUTOREPEAT_EN
                rc[i]  <= rc_n[i];
`endif
            end
        end
    end
    // Pulses are computed here and registered so they coincide with the state change.
    always_comb begin
        hp_n = '0;
        sp_n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            st_n[i]  = st[i];
            cnt_n[i] = cnt[i];
`ifdef HOLD_AUTOREPEAT_EN
            rc_n[i]  = '0;
`endif
            case (st[i])
                IDLE: begin
                    st_n[i]  = s2[i] ? PRESSING : IDLE;
                    cnt_n[i] = s2[i] ? CW'(1) : '0;
                end
                PRESSING: begin
                    if (!s2[i]) begin
                        st_n[i]  = IDLE;
                        cnt_n[i] = '0;
                        sp_n[i]  = cnt[i] >= MINP;
                    end else if (cnt[i] == HMAX) begin
                        st_n[i] = HELD;
                        hp_n[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt[i] + CW'(1);
                    end
                end
                HELD: begin
                    if (!s2[i]) begin
                        st_n[i]  = IDLE;
                        cnt_n[i] = '0;
                    end
`ifdef HOLD_AUTOREPEAT_EN
                    else begin
                        hp_n[i] = rc[i] == RMAX;
                        rc_n[i] = rc[i] == RMAX ? '0 : rc[i] + RW'(1);
                    end
`endif
                end
                default: begin
                    st_n[i]  = IDLE;
                    cnt_n[i] = '0;
                end
            endcase
        end
    end
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            held[i] = st[i] == HELD;
            busy    = busy | (st[i] != IDLE);
        end
    end
endmodule

// File: tb/tb_hold_detect_multi.sv
// tb_hold_detect_multi: directed and random stimulus checked against a run-length reference model
module tb_hold_detect_multi;
    localparam int CH = 2, HC = 20, MP = 4, RP = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [CH-1:0] btn_in = '0;
    logic [CH-1:0] held, hold_pulse, short_press;
    logic busy;
    int vectors = 0;
    int miscompares = 0;
    int run [CH];
    logic [CH-1:0] h0 = '0, h1 = '0, fin, eh = '0, ehp = '0, esp = '0;
    logic eb = 1'b0;
    logic [CH-1:0] lvl = '0;
    int rem [CH];

    always #5 clk = ~clk;

    hold_detect_multi #(
        .CHANNELS(CH), .HOLD_CYCLES(HC), .MIN_PRESS_CYCLES(MP), .REPEAT_CYCLES(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .held(held),
        .hold_pulse(hold_pulse), .short_press(short_press), .busy(busy)
    );

    // The model tracks, per channel, how many consecutive high synchronized samples
    // the detector has seen; sync is btn_in as sampled two edges earlier.
    task automatic step(input logic [CH-1:0] b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        ehp = '0;
        esp = '0;
        if (r) begin
            h0 = '0;
            h1 = '0;
            for (int i = 0; i < CH; i++) run[i] = 0;
        end else begin
            fin = h1;
            h1  = h0;
            h0  = b;
            for (int i = 0; i < CH; i++) begin
                if (fin[i]) begin
                    run[i] = run[i] + 1;
                    ehp[i] = run[i] == HC;
`ifdef HOLD_AUTOREPEAT_EN
                    if (run[i] > HC && (run[i] - HC) % RP == 0) ehp[i] = 1'b1;
`endif
                end else begin
                    esp[i] = run[i] >= MP && run[i] < HC;
                    run[i] = 0;
                end
            end
        end
        eb = 1'b0;
        for (int i = 0; i < CH; i++) begin
            eh[i] = run[i] >= HC;
            eb    = eb | (run[i] > 0);
        end
        #1;
        vectors++;
        assert (held === eh) else begin
            miscompares++;
            $error("FAIL held obs=%b exp=%b at vector %0d", held, eh, vectors);
        end
        assert (hold_pulse === ehp) else begin
            miscompares++;
            $error("FAIL hold_pulse obs=%b exp=%b at vector %0d", hold_pulse, ehp, vectors);
        end
        assert (short_press === esp) else begin
            miscompares++;
            $error("FAIL short_press obs=%b exp=%b at vector %0d", short_press, esp, vectors);
        end
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL busy obs=%b exp=%b at vector %0d", busy, eb, vectors);
        end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) run[i] = 0;
        step(2'b00, 1'b1);
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);
        for (int n = 0; n < 45; n++) step(2'b01, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 10; n++) step(2'b01, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 3; n++) step(2'b01, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 4; n++) step(2'b10, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        step(2'b11, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 19; n++) step(2'b10, 1'b0);
        for (int n = 0; n < 6; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 24; n++) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        for (int n = 0; n < 30; n++) step(2'b11, 1'b0);
        for (int n = 0; n < 8; n++) step(2'b00, 1'b0);
        for (int n = 0; n < 12; n++) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        for (int n = 0; n < 8; n++) step(2'b00, 1'b0);
        for (int i = 0; i < CH; i++) rem[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < CH; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(1, 45));
                end
                rem[i] = rem[i] - 1;
            end
            step(lvl, $urandom_range(0, 199) == 0);
        end
        for (int n = 0; n < 8; n++) step(2'b00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
